// File: rtl/vreg_operand_fetch_pkg.sv
// Shared types and sizes for the VEGGIE operand-fetch client.
package vreg_operand_fetch_pkg;

    localparam int unsigned READ_PORTS      = 4;
    localparam int unsigned MASK_BANK_COUNT = 2;
    localparam int unsigned VSEL_W          = 5;
    localparam int unsigned MSEL_W          = 3;
    localparam int unsigned VREG_W          = 64;
    localparam int unsigned VMASK_W         = 32;
    localparam int unsigned FETCH_TIMEOUT   = 64;

    typedef logic [VSEL_W-1:0]  vsel_t;
    typedef logic [MSEL_W-1:0]  mask_sel_t;
    typedef logic [VREG_W-1:0]  vreg_t;
    typedef logic [VMASK_W-1:0] vmask_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISP} fetch_state_t;

    typedef struct packed {
        vsel_t     vs1;
        vsel_t     vs2;
        logic      vs1_en;
        logic      vs2_en;
        logic      vm;
        mask_sel_t vms;
        vsel_t     vd;
    } fetch_req_t;

    typedef struct packed {
        vreg_t  v1;
        vreg_t  v2;
        vmask_t vmask;
        logic   vm;
        vsel_t  vd;
    } operand_bundle_t;

endpackage

// File: rtl/vreg_operand_fetch_if.sv
// Issue, VEGGIE read and operand-dispatch signals; slave = fetch unit, master = its environment.
interface vreg_operand_fetch_if;
    import vreg_operand_fetch_pkg::*;

    logic      issue_valid;
    logic      issue_ready;
    vsel_t     issue_vs1;
    vsel_t     issue_vs2;
    logic      issue_vs1_en;
    logic      issue_vs2_en;
    logic      issue_vm;
    mask_sel_t issue_vms;
    vsel_t     issue_vd;

    vsel_t     [READ_PORTS-1:0]      vg_vs;
    logic      [READ_PORTS-1:0]      vg_ren;
    mask_sel_t [MASK_BANK_COUNT-1:0] vg_vms;
    logic      [MASK_BANK_COUNT-1:0] vg_mren;
    logic                            vg_ready;
    vreg_t     [READ_PORTS-1:0]      vg_vreg;
    logic      [READ_PORTS-1:0]      vg_dvalid;
    vmask_t    [1:0]                 vg_vmask;
    logic      [1:0]                 vg_mvalid;

    logic   op_valid;
    logic   op_ready;
    vreg_t  op_v1;
    vreg_t  op_v2;
    vmask_t op_vmask;
    logic   op_vm;
    vsel_t  op_vd;
    logic   err_timeout;

    modport slave (
        input  issue_valid, issue_vs1, issue_vs2, issue_vs1_en, issue_vs2_en,
               issue_vm, issue_vms, issue_vd,
               vg_ready, vg_vreg, vg_dvalid, vg_vmask, vg_mvalid, op_ready,
        output issue_ready, vg_vs, vg_ren, vg_vms, vg_mren,
               op_valid, op_v1, op_v2, op_vmask, op_vm, op_vd, err_timeout
    );

    modport master (
        output issue_valid, issue_vs1, issue_vs2, issue_vs1_en, issue_vs2_en,
               issue_vm, issue_vms, issue_vd,
               vg_ready, vg_vreg, vg_dvalid, vg_vmask, vg_mvalid, op_ready,
        input  issue_ready, vg_vs, vg_ren, vg_vms, vg_mren,
               op_valid, op_v1, op_v2, op_vmask, op_vm, op_vd, err_timeout
    );

endinterface

// File: rtl/vreg_operand_fetch_capture.sv
// One operand slot: pending flag plus data register, loaded on issue and filled by returning read data.
module operand_capture_reg #(
    parameter type T       = logic [31:0],
    parameter T    RST_VAL = '0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic load_pend_i,
    input  logic cap_i,
    input  logic clr_i,
    input  T     data_i,
    output logic pend_o,
    output T     data_o
);

    logic pend_q;
    T     data_q;

    // Load restores the "not fetched" value so a disabled operand reads as its default.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            data_q <= RST_VAL;
        end else if (load_i) begin
            pend_q <= load_pend_i;
            data_q <= RST_VAL;
        end else if (clr_i) begin
            pend_q <= 1'b0;
        end else if (cap_i && pend_q) begin
            pend_q <= 1'b0;
            data_q <= data_i;
        end
    end

    assign pend_o = pend_q;
    assign data_o = data_q;

endmodule

// File: rtl/vreg_operand_fetch.sv
// Fetches vs1/vs2/mask for one instruction from VEGGIE and hands a complete operand bundle downstream.
module vreg_operand_fetch
    import vreg_operand_fetch_pkg::*;
#(
    parameter int unsigned VS1_PORT  = 0,
    parameter int unsigned VS2_PORT  = 1,
    parameter int unsigned MASK_PORT = 0,
    parameter int unsigned TIMEOUT   = FETCH_TIMEOUT
) (
    input logic                  clk_i,
    input logic                  rst_i,
    vreg_operand_fetch_if.slave  bus
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    fetch_state_t    state_q;
    logic [TW-1:0]   timer_q;
    fetch_req_t      req_q;
    logic            err_q;

    logic            issue_ready_c;
    logic            accept_c;
    logic            in_wait_c;
    logic            abort_c;
    logic [2:0]      new_pend_c;
    logic [2:0]      pend_q;
    logic [2:0]      got_c;
    logic [2:0]      pend_d;
    logic            cap_v1_c;
    logic            cap_v2_c;
    logic            cap_m_c;
    vreg_t           v1_q;
    vreg_t           v2_q;
    vmask_t          vmask_q;
    operand_bundle_t op_c;

    assign issue_ready_c = (state_q == IDLE) || ((state_q == DISP) && bus.op_ready);
    assign accept_c      = bus.issue_valid && issue_ready_c;
    assign new_pend_c    = {bus.issue_vm, bus.issue_vs2_en, bus.issue_vs1_en};
    assign in_wait_c     = (state_q == WAIT);

    assign cap_v1_c = in_wait_c && bus.vg_dvalid[VS1_PORT];
    assign cap_v2_c = in_wait_c && bus.vg_dvalid[VS2_PORT];
    assign cap_m_c  = in_wait_c && bus.vg_mvalid[MASK_PORT];

    // Valids only count against operands still outstanding.
    assign got_c   = {cap_m_c, cap_v2_c, cap_v1_c} & pend_q;
    assign pend_d  = pend_q & ~got_c;
    assign abort_c = in_wait_c && (pend_d != 3'b000) && (timer_q == TW'(TIMEOUT - 1));

    operand_capture_reg #(.T(vreg_t), .RST_VAL(vreg_t'('0))) u_cap_v1 (
        .clk_i, .rst_i,
        .load_i(accept_c), .load_pend_i(new_pend_c[0]),
        .cap_i(cap_v1_c), .clr_i(abort_c),
        .data_i(bus.vg_vreg[VS1_PORT]),
        .pend_o(pend_q[0]), .data_o(v1_q)
    );

    operand_capture_reg #(.T(vreg_t), .RST_VAL(vreg_t'('0))) u_cap_v2 (
        .clk_i, .rst_i,
        .load_i(accept_c), .load_pend_i(new_pend_c[1]),
        .cap_i(cap_v2_c), .clr_i(abort_c),
        .data_i(bus.vg_vreg[VS2_PORT]),
        .pend_o(pend_q[1]), .data_o(v2_q)
    );

    operand_capture_reg #(.T(vmask_t), .RST_VAL(vmask_t'('1))) u_cap_mask (
        .clk_i, .rst_i,
        .load_i(accept_c), .load_pend_i(new_pend_c[2]),
        .cap_i(cap_m_c), .clr_i(abort_c),
        .data_i(bus.vg_vmask[MASK_PORT]),
        .pend_o(pend_q[2]), .data_o(vmask_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= abort_c;
            if (accept_c) begin
                req_q <= '{vs1: bus.issue_vs1, vs2: bus.issue_vs2,
                           vs1_en: bus.issue_vs1_en, vs2_en: bus.issue_vs2_en,
                           vm: bus.issue_vm, vms: bus.issue_vms, vd: bus.issue_vd};
            end
            unique case (state_q)
                IDLE: begin
                    if (accept_c) state_q <= (new_pend_c != 3'b000) ? REQ : DISP;
                end
                REQ: begin
                    if (bus.vg_ready) begin
                        state_q <= WAIT;
                        timer_q <= '0;
                    end
                end
                WAIT: begin
                    timer_q <= timer_q + TW'(1);
                    if (pend_d == 3'b000) state_q <= DISP;
                    else if (abort_c)     state_q <= IDLE;
                end
                DISP: begin
                    if (accept_c)         state_q <= (new_pend_c != 3'b000) ? REQ : DISP;
                    else if (bus.op_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Requests are decoded from registered state only, so they hold steady while VEGGIE stalls.
    always_comb begin
        bus.vg_ren  = '0;
        bus.vg_vs   = '0;
        bus.vg_mren = '0;
        bus.vg_vms  = '0;
        if (state_q == REQ) begin
            bus.vg_ren[VS1_PORT]   = pend_q[0];
            bus.vg_vs[VS1_PORT]    = req_q.vs1;
            bus.vg_ren[VS2_PORT]   = pend_q[1];
            bus.vg_vs[VS2_PORT]    = req_q.vs2;
            bus.vg_mren[MASK_PORT] = pend_q[2];
            bus.vg_vms[MASK_PORT]  = req_q.vms;
        end
    end

    assign op_c = '{v1: v1_q, v2: v2_q, vmask: vmask_q, vm: req_q.vm, vd: req_q.vd};

    assign bus.issue_ready = issue_ready_c;
    assign bus.op_valid    = (state_q == DISP);
    assign bus.op_v1       = op_c.v1;
    assign bus.op_v2       = op_c.v2;
    assign bus.op_vmask    = op_c.vmask;
    assign bus.op_vm       = op_c.vm;
    assign bus.op_vd       = op_c.vd;
    assign bus.err_timeout = err_q;

    logic unused_sig;
    assign unused_sig = ^{bus.vg_vreg, bus.vg_dvalid, bus.vg_vmask, bus.vg_mvalid,
                          req_q.vs1_en, req_q.vs2_en};

endmodule

// File: tb/tb_vreg_operand_fetch.sv
// Directed bench for vreg_operand_fetch with a queue scoreboard checked by an independent monitor.
module tb_vreg_operand_fetch;
    import vreg_operand_fetch_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    operand_bundle_t sb[$];

    vreg_operand_fetch_if bus();

    vreg_operand_fetch #(
        .VS1_PORT(0), .VS2_PORT(1), .MASK_PORT(0), .TIMEOUT(64)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam vreg_t DA = 64'h0123_4567_89AB_CDEF;
    localparam vreg_t DB = 64'hFEDC_BA98_7654_3210;
    localparam vreg_t DC = 64'h1111_2222_3333_4444;
    localparam vreg_t DD = 64'h5555_6666_7777_8888;
    localparam vreg_t DE = 64'hDEAD_BEEF_0000_0001;
    localparam vreg_t DF = 64'hCAFE_F00D_0000_0002;
    localparam vreg_t DG = 64'h0F0F_0F0F_F0F0_F0F0;
    localparam vreg_t DH = 64'hA5A5_A5A5_5A5A_5A5A;
    localparam vreg_t DJ = 64'h0000_0000_0000_0077;
    localparam vreg_t DK = 64'h8000_0000_0000_0000;
    localparam vreg_t DX = 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input vsel_t vs1, input vsel_t vs2, input logic e1, input logic e2,
                               input logic vm, input mask_sel_t vms, input vsel_t vd);
        bus.issue_valid  = 1'b1;
        bus.issue_vs1    = vs1;
        bus.issue_vs2    = vs2;
        bus.issue_vs1_en = e1;
        bus.issue_vs2_en = e2;
        bus.issue_vm     = vm;
        bus.issue_vms    = vms;
        bus.issue_vd     = vd;
    endtask

    task automatic push(input vreg_t v1, input vreg_t v2, input vmask_t m, input logic vm, input vsel_t vd);
        sb.push_back('{v1: v1, v2: v2, vmask: m, vm: vm, vd: vd});
    endtask

    // Monitor: every accepted bundle must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.op_valid && bus.op_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got bundle v1=%h vd=%0d expected none", bus.op_v1, bus.op_vd);
            end else begin
                operand_bundle_t e;
                e = sb.pop_front();
                check("sb_v1",    bus.op_v1,    e.v1);
                check("sb_v2",    bus.op_v2,    e.v2);
                check("sb_vmask", 64'(bus.op_vmask), 64'(e.vmask));
                check("sb_vm",    64'(bus.op_vm),    64'(e.vm));
                check("sb_vd",    64'(bus.op_vd),    64'(e.vd));
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_vs1 = '0; bus.issue_vs2 = '0;
        bus.issue_vs1_en = 1'b0; bus.issue_vs2_en = 1'b0;
        bus.issue_vm = 1'b0; bus.issue_vms = '0; bus.issue_vd = '0;
        bus.vg_ready = 1'b1;
        bus.vg_vreg = '0; bus.vg_dvalid = '0;
        bus.vg_vmask = '0; bus.vg_mvalid = '0;
        bus.op_ready = 1'b1;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_op_valid",    64'(bus.op_valid), 64'(0));
        check("rst_issue_ready", 64'(bus.issue_ready), 64'(1));
        check("rst_vg_ren",      64'(bus.vg_ren), 64'(0));
        check("rst_vmask",       64'(bus.op_vmask), 64'hFFFF_FFFF);
        check("rst_v1",          bus.op_v1, 64'(0));
        check("rst_err",         64'(bus.err_timeout), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // No-operand instruction goes straight to DISP
        drive_issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd21);
        push('0, '0, 32'hFFFF_FFFF, 1'b0, 5'd21);
        tick();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("t0_op_valid", 64'(bus.op_valid), 64'(1));
        check("t0_no_ren",   64'(bus.vg_ren), 64'(0));
        tick();
        check("t0_drained", 64'(sb.size()), 64'(0));

        // Basic two-operand fetch, data two cycles after the request
        drive_issue(5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 3'd0, 5'd7);
        push(DA, DB, 32'hFFFF_FFFF, 1'b0, 5'd7);
        @(negedge clk);
        check("t1_issue_ready", 64'(bus.issue_ready), 64'(1));
        tick();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("t1_ren",  64'(bus.vg_ren), 64'b0011);
        check("t1_vs0",  64'(bus.vg_vs[0]), 64'd3);
        check("t1_vs1",  64'(bus.vg_vs[1]), 64'd5);
        check("t1_mren", 64'(bus.vg_mren), 64'(0));
        tick();
        bus.vg_dvalid[3] = 1'b1; bus.vg_vreg[3] = DX;
        tick();
        bus.vg_dvalid = '0;
        bus.vg_dvalid[0] = 1'b1; bus.vg_vreg[0] = DA;
        bus.vg_dvalid[1] = 1'b1; bus.vg_vreg[1] = DB;
        @(negedge clk);
        check("t1_not_yet_valid", 64'(bus.op_valid), 64'(0));
        tick();
        bus.vg_dvalid = '0;
        @(negedge clk);
        check("t1_op_valid", 64'(bus.op_valid), 64'(1));
        tick();
        check("t1_drained", 64'(sb.size()), 64'(0));

        // VEGGIE stalls the request for three cycles
        bus.vg_ready = 1'b0;
        drive_issue(5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 3'd0, 5'd4);
        push(DC, DD, 32'hFFFF_FFFF, 1'b0, 5'd4);
        tick();
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold_ren", 64'(bus.vg_ren), 64'b0011);
            check("t2_hold_vs0", 64'(bus.vg_vs[0]), 64'd2);
            check("t2_hold_vs1", 64'(bus.vg_vs[1]), 64'd9);
            check("t2_hold_issue_ready", 64'(bus.issue_ready), 64'(0));
            tick();
        end
        bus.vg_ready = 1'b1;
        tick();
        bus.vg_dvalid[0] = 1'b1; bus.vg_vreg[0] = DC;
        bus.vg_dvalid[1] = 1'b1; bus.vg_vreg[1] = DD;
        @(negedge clk);
        check("t2_ren_dropped", 64'(bus.vg_ren), 64'(0));
        tick();
        bus.vg_dvalid = '0;
        tick();
        check("t2_drained", 64'(sb.size()), 64'(0));

        // Bank conflict: vs1 at +1, mask at +2, vs2 at +4
        drive_issue(5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 3'd2, 5'd10);
        push(DE, DF, 32'h0000_00F0, 1'b1, 5'd10);
        tick();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("t3_ren",  64'(bus.vg_ren), 64'b0011);
        check("t3_mren", 64'(bus.vg_mren), 64'b01);
        check("t3_vms",  64'(bus.vg_vms[0]), 64'd2);
        tick();
        bus.vg_dvalid[0] = 1'b1; bus.vg_vreg[0] = DE;
        tick();
        bus.vg_dvalid = '0;
        bus.vg_mvalid[0] = 1'b1; bus.vg_vmask[0] = 32'h0000_00F0;
        tick();
        bus.vg_mvalid[0] = 1'b1; bus.vg_vmask[0] = 32'hFFFF_0000;
        bus.vg_dvalid[2] = 1'b1; bus.vg_vreg[2] = DX;
        @(negedge clk);
        check("t3_wait_valid", 64'(bus.op_valid), 64'(0));
        tick();
        bus.vg_mvalid = '0; bus.vg_dvalid = '0;
        bus.vg_dvalid[1] = 1'b1; bus.vg_vreg[1] = DF;
        @(negedge clk);
        check("t3_before_last", 64'(bus.op_valid), 64'(0));
        tick();
        bus.vg_dvalid = '0;
        @(negedge clk);
        check("t3_after_last", 64'(bus.op_valid), 64'(1));
        tick();
        check("t3_drained", 64'(sb.size()), 64'(0));

        // Consumer back-pressure, then back-to-back issue from DISP
        bus.op_ready = 1'b0;
        drive_issue(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd1);
        push(DG, '0, 32'hFFFF_FFFF, 1'b0, 5'd1);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        bus.vg_dvalid[0] = 1'b1; bus.vg_vreg[0] = DG;
        tick();
        bus.vg_dvalid = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_valid", 64'(bus.op_valid), 64'(1));
            check("t4_stall_v1",    bus.op_v1, DG);
            check("t4_stall_v2",    bus.op_v2, 64'(0));
            check("t4_stall_ready", 64'(bus.issue_ready), 64'(0));
            tick();
        end
        bus.op_ready = 1'b1;
        drive_issue(5'd15, 5'd8, 1'b0, 1'b1, 1'b1, 3'd5, 5'd2);
        push('0, DH, 32'h0F0F_0F0F, 1'b1, 5'd2);
        @(negedge clk);
        check("t4_b2b_ready", 64'(bus.issue_ready), 64'(1));
        tick();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("t4_b2b_ren",   64'(bus.vg_ren), 64'b0010);
        check("t4_b2b_vs1",   64'(bus.vg_vs[1]), 64'd8);
        check("t4_b2b_mren",  64'(bus.vg_mren), 64'b01);
        check("t4_b2b_vms",   64'(bus.vg_vms[0]), 64'd5);
        check("t4_b2b_valid", 64'(bus.op_valid), 64'(0));
        tick();
        bus.vg_mvalid[0] = 1'b1; bus.vg_vmask[0] = 32'h0F0F_0F0F;
        bus.vg_dvalid[1] = 1'b1; bus.vg_vreg[1] = DH;
        bus.vg_dvalid[0] = 1'b1; bus.vg_vreg[0] = DX;
        tick();
        bus.vg_mvalid = '0; bus.vg_dvalid = '0;
        tick();
        check("t4_drained", 64'(sb.size()), 64'(0));

        // Timeout: no data ever returns
        drive_issue(5'd11, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd3);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        for (int i = 0; i < 63; i++) tick();
        @(negedge clk);
        check("t5_err_early",   64'(bus.err_timeout), 64'(0));
        check("t5_still_wait",  64'(bus.issue_ready), 64'(0));
        tick();
        @(negedge clk);
        check("t5_err_pulse",   64'(bus.err_timeout), 64'(1));
        check("t5_idle_ready",  64'(bus.issue_ready), 64'(1));
        check("t5_op_valid",    64'(bus.op_valid), 64'(0));
        tick();
        bus.vg_dvalid[0] = 1'b1; bus.vg_vreg[0] = DX;
        @(negedge clk);
        check("t5_err_single",  64'(bus.err_timeout), 64'(0));
        tick();
        bus.vg_dvalid = '0;
        @(negedge clk);
        check("t5_stray_ignored", 64'(bus.op_valid), 64'(0));
        check("t5_stray_ready",   64'(bus.issue_ready), 64'(1));
        tick();

        // Reset while waiting, late data must be ignored
        drive_issue(5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 3'd0, 5'd9);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.vg_dvalid[0] = 1'b1; bus.vg_vreg[0] = DX;
        bus.vg_dvalid[1] = 1'b1; bus.vg_vreg[1] = DX;
        @(negedge clk);
        check("t6_rst_ready", 64'(bus.issue_ready), 64'(1));
        check("t6_rst_valid", 64'(bus.op_valid), 64'(0));
        tick();
        bus.vg_dvalid = '0;
        @(negedge clk);
        check("t6_late_valid", 64'(bus.op_valid), 64'(0));
        tick();
        drive_issue(5'd12, 5'd13, 1'b1, 1'b1, 1'b1, 3'd3, 5'd14);
        push(DJ, DK, 32'h1234_5678, 1'b1, 5'd14);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        bus.vg_dvalid[1] = 1'b1; bus.vg_vreg[1] = DK;
        bus.vg_mvalid[0] = 1'b1; bus.vg_vmask[0] = 32'h1234_5678;
        tick();
        bus.vg_dvalid = '0; bus.vg_mvalid = '0;
        bus.vg_dvalid[0] = 1'b1; bus.vg_vreg[0] = DJ;
        tick();
        bus.vg_dvalid = '0;
        tick();
        tick();
        check("t6_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
